scr1_dmem_vec_responder: RTL



---
 rtl/scr1_dmem_vec_responder.sv | 258 +++++++++++++++++++++++++
 1 files changed

// File: rtl/scr1_dmem_vec_responder.sv
// DMEM target for scalar and vector LSU accesses, backed by a word-organised
// array (one row holds LANE consecutive words so a vector hits exactly one row).

package scr1_dmem_vec_pkg;

    localparam int unsigned SCR1_DMEM_AWIDTH = 32;

    typedef enum logic [1:0] {
        MemCmdRd = 2'b00,
        MemCmdWr = 2'b01
    } type_scr1_mem_cmd_e;

    typedef enum logic [2:0] {
        MemWidthByte   = 3'd0,
        MemWidthHword  = 3'd1,
        MemWidthWord   = 3'd2,
        MemWidthVector = 3'd3
    } type_scr1_mem_width_e;

    typedef enum logic [1:0] {
        MemRespNotRdy = 2'b00,
        MemRespRdyOk  = 2'b01,
        MemRespRdyEr  = 2'b10
    } type_scr1_mem_resp_e;

endpackage

module scr1_dmem_vec_responder
    import scr1_dmem_vec_pkg::*;
#(
    parameter int unsigned                 LANE        = 16,
    parameter int unsigned                 DEPTH_WORDS = 4096,
    parameter logic [SCR1_DMEM_AWIDTH-1:0] BASE_ADDR   = 32'h0001_0000,
    parameter int unsigned                 WAIT_CYCLES = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          lsu2dmem_req,
    input  type_scr1_mem_cmd_e            lsu2dmem_cmd,
    input  type_scr1_mem_width_e          lsu2dmem_width,
    input  logic [SCR1_DMEM_AWIDTH-1:0]   lsu2dmem_addr,
    input  logic [LANE-1:0][31:0]         lsu2dmem_wdata,
    output logic                          dmem2lsu_req_ack,
    output logic [LANE-1:0][31:0]         dmem2lsu_rdata,
    output type_scr1_mem_resp_e           dmem2lsu_resp
);

    localparam int unsigned LB     = $clog2(LANE);
    localparam int unsigned BANK_W = (LB > 0) ? LB : 1;
    localparam int unsigned ROWS   = DEPTH_WORDS / LANE;
    localparam int unsigned ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [33:0] MEM_BYTES = 34'(DEPTH_WORDS) << 2;
    localparam logic [31:0] VEC_MASK  = 32'(LANE * 4 - 1);

    typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

    state_e                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    type_scr1_mem_resp_e   resp_q, resp_d;
    logic [LANE-1:0][31:0] rdata_q, rdata_d;
    type_scr1_mem_cmd_e    cmd_q, cmd_d;
    type_scr1_mem_width_e  width_q, width_d;
    logic [31:0]           addr_q, addr_d;
    logic [LANE-1:0][31:0] wdata_q, wdata_d;

    logic [LANE*32-1:0]    mem_q [ROWS];

    type_scr1_mem_cmd_e    cmd_n, sel_cmd;
    type_scr1_mem_width_e  width_n, sel_width;
    logic [31:0]           sel_addr;
    logic [LANE-1:0][31:0] sel_wdata;

    logic [31:0]           offset;
    logic [29:0]           word_idx;
    logic [1:0]            byte_lo;
    logic [ROW_W-1:0]      row;
    logic [BANK_W-1:0]     bank;
    logic [33:0]           access_bytes;
    logic                  misalign;
    logic                  err;

    logic [LANE*32-1:0]    rd_row;
    logic [31:0]           rd_word;
    logic [LANE-1:0][31:0] rd_vec;
    logic [LANE*32-1:0]    wr_data;
    logic [LANE*4-1:0]     wr_be;
    logic                  mem_we;

    // Fold unknown cmd/width encodings onto a plain WORD read.
    always_comb begin
        cmd_n = (lsu2dmem_cmd == MemCmdWr) ? MemCmdWr : MemCmdRd;
        case (lsu2dmem_width)
            MemWidthByte, MemWidthHword, MemWidthWord, MemWidthVector: width_n = lsu2dmem_width;
            default: width_n = MemWidthWord;
        endcase
    end

    // In IDLE decode the incoming request (WAIT_CYCLES=0 path), otherwise the latched one.
    always_comb begin
        if (state_q == StIdle) begin
            sel_cmd   = cmd_n;
            sel_width = width_n;
            sel_addr  = lsu2dmem_addr;
            sel_wdata = lsu2dmem_wdata;
        end else begin
            sel_cmd   = cmd_q;
            sel_width = width_q;
            sel_addr  = addr_q;
            sel_wdata = wdata_q;
        end
    end

    // Address decode and error flag; BASE_ADDR alignment makes offset alignment equal addr's.
    always_comb begin
        offset   = sel_addr - BASE_ADDR;
        word_idx = offset[31:2];
        byte_lo  = offset[1:0];
        row      = ROW_W'(word_idx >> LB);
        bank     = (LB == 0) ? '0 : BANK_W'(word_idx);
        access_bytes = 34'd4;
        misalign     = 1'b0;
        case (sel_width)
            MemWidthByte: access_bytes = 34'd1;
            MemWidthHword: begin
                access_bytes = 34'd2;
                misalign     = byte_lo[0];
            end
            MemWidthVector: begin
                access_bytes = 34'(LANE * 4);
                misalign     = |(offset & VEC_MASK);
            end
            default: misalign = |byte_lo;
        endcase
        err = (sel_addr < BASE_ADDR) || (({2'b00, offset} + access_bytes) > MEM_BYTES) || misalign;
    end

    // Read path: select the row, then narrow for scalar accesses (zero-extended).
    always_comb begin
        rd_row  = mem_q[row];
        rd_word = rd_row[{bank, 5'b0} +: 32];
        rd_vec  = '0;
        case (sel_width)
            MemWidthByte:   rd_vec[0] = {24'b0, rd_word[{byte_lo, 3'b0} +: 8]};
            MemWidthHword:  rd_vec[0] = {16'b0, rd_word[{byte_lo[1], 4'b0} +: 16]};
            MemWidthVector: rd_vec    = rd_row;
            default:        rd_vec[0] = rd_word;
        endcase
    end

    // Write path: replicate scalar data across the row and steer it with byte enables.
    always_comb begin
        wr_data = '0;
        wr_be   = '0;
        case (sel_width)
            MemWidthByte: begin
                wr_data                 = {(LANE * 4){sel_wdata[0][7:0]}};
                wr_be[{bank, byte_lo}]  = 1'b1;
            end
            MemWidthHword: begin
                wr_data                          = {(LANE * 2){sel_wdata[0][15:0]}};
                wr_be[{bank, byte_lo[1], 1'b0}]  = 1'b1;
                wr_be[{bank, byte_lo[1], 1'b1}]  = 1'b1;
            end
            MemWidthVector: begin
                wr_data = sel_wdata;
                wr_be   = '1;
            end
            default: begin
                wr_data                  = {LANE{sel_wdata[0]}};
                wr_be[{bank, 2'b00} +: 4] = 4'hF;
            end
        endcase
        // A reset landing on the RESP edge must drop the pending write.
        mem_we = (state_q == StResp) && (cmd_q == MemCmdWr) && !err && !rst;
    end

    // Array storage; never cleared by reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int unsigned b = 0; b < LANE * 4; b++) begin
                if (wr_be[b]) begin
                    mem_q[row][b*8 +: 8] <= wr_data[b*8 +: 8];
                end
            end
        end
    end

    // FSM next state, request latch and registered response.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        resp_d  = MemRespNotRdy;
        rdata_d = rdata_q;
        cmd_d   = cmd_q;
        width_d = width_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            StIdle: begin
                if (lsu2dmem_req) begin
                    cmd_d   = cmd_n;
                    width_d = width_n;
                    addr_d  = lsu2dmem_addr;
                    wdata_d = lsu2dmem_wdata;
                    if (WAIT_CYCLES == 0) begin
                        state_d = StResp;
                    end else begin
                        cnt_d   = 4'(WAIT_CYCLES - 1);
                        state_d = StBusy;
                    end
                end
            end
            StBusy: begin
                if (cnt_q == 4'd0) begin
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = StIdle;
        endcase
        // err/rd_vec are decoded from the same request that is entering RESP.
        if (state_d == StResp) begin
            resp_d = err ? MemRespRdyEr : MemRespRdyOk;
            if (sel_cmd == MemCmdRd) begin
                rdata_d = err ? '0 : rd_vec;
            end
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            resp_q  <= MemRespNotRdy;
            rdata_q <= '0;
            cmd_q   <= MemCmdRd;
            width_q <= MemWidthWord;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            resp_q  <= resp_d;
            rdata_q <= rdata_d;
            cmd_q   <= cmd_d;
            width_q <= width_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign dmem2lsu_req_ack = (state_q == StIdle);
    assign dmem2lsu_resp    = resp_q;
    assign dmem2lsu_rdata   = rdata_q;

endmodule
